// File: rtl/ext_mem_router_pkg.sv
// ext_mem_router_pkg: shared types and helpers for the external memory router.
//   state_e       - access FSM states (idle / access / done)
//   ch_decode()   - extracts the channel index from a left-justified address
//   RDATA_TIMEOUT - read data returned when an access is aborted by the watchdog
package ext_mem_router_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  // Widest address / data the helpers below accept.
  localparam int unsigned AddrMaxW = 64;
  localparam int unsigned MaxDataW = 256;

  localparam logic [MaxDataW-1:0] RDATA_TIMEOUT = '1;

  // addr must be left-justified in AddrMaxW bits; returns its top sel_w bits.
  function automatic logic [7:0] ch_decode(input logic [AddrMaxW-1:0] addr,
                                           input int unsigned         sel_w);
    return 8'(addr >> (AddrMaxW - sel_w));
  endfunction

endpackage

// File: rtl/ext_mem_router_wdt.sv
// ext_mem_router_wdt: access watchdog for the external memory router.
//   clk, rst - clock, asynchronous active-high reset
//   clear    - zero the counter
//   enable   - count one cycle
//   expired  - high during the LIMIT-th enabled cycle since the last clear
module ext_mem_router_wdt
  import ext_mem_router_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  // The counter holds the number of completed enabled cycles, so the cycle
  // in which it reads LIMIT-1 is the LIMIT-th one.
  assign expired = enable && (32'(cnt_q) == LIMIT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/ext_mem_router.sv
// ext_mem_router: routes CPU bus accesses to NUM_CH slave channels selected by
// the top SEL_W address bits, with a per-access IDLE/ACCESS/DONE handshake.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   addr_i, re_i, we_i        - CPU request (address, read / write strobe)
//   wdata_i, rdata_o          - CPU write data in, registered read data out
//   needWait_o                - CPU must hold its request while high
//   err_o                     - last access was unmapped (or timed out)
//   ch_addr_o, ch_wdata_o     - latched offset / write data, shared by channels
//   ch_re_o, ch_we_o          - one-hot registered channel strobes
//   ch_rdata_i, ch_needWait_i - per-channel read data and wait
// Build option: define EXT_MEM_ROUTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYC cycles of slave wait (returns all-ones read data, sets err_o).
module ext_mem_router
  import ext_mem_router_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic                     re_i,
  input  logic                     we_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     needWait_o,
  output logic                     err_o,
  output logic [ADDR_W-SEL_W-1:0]  ch_addr_o,
  output logic [DATA_W-1:0]        ch_wdata_o,
  output logic [NUM_CH-1:0]        ch_re_o,
  output logic [NUM_CH-1:0]        ch_we_o,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata_i,
  input  logic [NUM_CH-1:0]        ch_needWait_i
);

  localparam int unsigned OffW = ADDR_W - SEL_W;

  state_e            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic              is_write_q;

  logic              req;
  logic [SEL_W-1:0]  req_sel;
  logic              req_mapped;
  logic [NUM_CH-1:0] req_onehot;
  logic              sel_wait;
  logic [DATA_W-1:0] sel_rdata;
  logic              timeout;

  assign req        = re_i | we_i;
  assign req_sel    = SEL_W'(ch_decode({addr_i, {(AddrMaxW - ADDR_W){1'b0}}}, SEL_W));
  assign req_mapped = 32'(req_sel) < NUM_CH;

  assign needWait_o = ((state_q == StIdle) && req) || (state_q == StAccess);

  // Decode the incoming channel and mux the latched channel's response.
  always_comb begin
    req_onehot = '0;
    sel_wait   = 1'b0;
    sel_rdata  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(req_sel) == k) begin
        req_onehot[k] = 1'b1;
      end
      if (32'(sel_q) == k) begin
        sel_wait  = ch_needWait_i[k];
        sel_rdata = ch_rdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef EXT_MEM_ROUTER_TIMEOUT_EN
  ext_mem_router_wdt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != StAccess),
    .enable  (state_q == StAccess),
    .expired (timeout)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      is_write_q <= 1'b0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
      ch_addr_o  <= '0;
      ch_wdata_o <= '0;
      ch_re_o    <= '0;
      ch_we_o    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            ch_addr_o  <= addr_i[OffW-1:0];
            ch_wdata_o <= wdata_i;
            sel_q      <= req_sel;
            is_write_q <= we_i;
            if (req_mapped) begin
              err_o   <= 1'b0;
              state_q <= StAccess;
              if (we_i) begin
                ch_we_o <= req_onehot;
              end else begin
                ch_re_o <= req_onehot;
              end
            end else begin
              // Unmapped: reads return zero, writes are dropped.
              err_o   <= 1'b1;
              state_q <= StDone;
              if (!we_i) begin
                rdata_o <= '0;
              end
            end
          end
        end
        StAccess: begin
          if (!sel_wait) begin
            ch_re_o <= '0;
            ch_we_o <= '0;
            if (!is_write_q) begin
              rdata_o <= sel_rdata;
            end
            state_q <= StDone;
          end else if (timeout) begin
            ch_re_o <= '0;
            ch_we_o <= '0;
            err_o   <= 1'b1;
            if (!is_write_q) begin
              rdata_o <= RDATA_TIMEOUT[DATA_W-1:0];
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/ext_mem_router.md
# ext_mem_router

Parametrised successor to the fixed four-target external memory interface. Sits between the CPU bus master (address, read/write strobes, wait) and NUM_CH slave channels such as flash ROM, DRAM, SRAM and memory-mapped LED/IO. It decodes the upper address bits to a channel and registers the transaction. It runs a per-access handshake FSM, returns read data and wait to the CPU, and flags unmapped or timed-out accesses.

## Interface
Parameters:
- NUM_CH, 4: number of slave channels (1..2^SEL_W).
- ADDR_W, 24: CPU address width.
- DATA_W, 16: data width.
- SEL_W, 3: number of top address bits used as the channel index.
- TIMEOUT_CYC, 255: maximum ACCESS cycles before abort; only used with the timeout feature.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous reset, active-high.
- addr_i, in, ADDR_W: CPU address.
- re_i, in, 1: CPU read strobe.
- we_i, in, 1: CPU write strobe.
- wdata_i, in, DATA_W: CPU write data.
- rdata_o, out, DATA_W: registered read data.
- needWait_o, out, 1: CPU must hold the request while this is high.
- err_o, out, 1: the last access was unmapped or timed out.
- ch_addr_o, out, ADDR_W-SEL_W: latched offset, shared by all channels.
- ch_wdata_o, out, DATA_W: latched write data, shared by all channels.
- ch_re_o, out, NUM_CH: one-hot read strobes.
- ch_we_o, out, NUM_CH: one-hot write strobes.
- ch_rdata_i, in, NUM_CH*DATA_W: slave read data; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_needWait_i, in, NUM_CH: per-slave wait.

## Operation
- Channel index sel = addr_i[ADDR_W-1 -: SEL_W].
- An address is unmapped when sel >= NUM_CH.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - On re_i|we_i, latch the offset, wdata, sel and is_write.
  - is_write = we_i. we_i wins if both strobes are high.
  - Clear err_o.
  - Go to ACCESS if mapped; go to DONE with err_o=1 if unmapped.
- ACCESS:
  - ch_re_o[sel] or ch_we_o[sel] is high; all other strobes are low.
  - When ch_needWait_i[sel]=0: latch the read data (reads only) into rdata_o and go to DONE.
- DONE:
  - All strobes are low.
  - Go to IDLE unconditionally.
  - The CPU drops its strobe, or presents a new request, in this cycle. A request present during DONE is accepted in the following IDLE cycle.
- Unmapped read: rdata_o = 0. Unmapped write: dropped.
- rdata_o holds its value until the next completed read.
- err_o is sticky until the next accepted request.

## Timing
- Reset values: state IDLE; all ch_re_o/ch_we_o = 0; needWait_o = 0; rdata_o = 0; err_o = 0; ch_addr_o = 0; ch_wdata_o = 0.
- Reset takes effect immediately, including mid-access: strobes drop asynchronously.
- needWait_o = (state==IDLE & (re_i|we_i)) | state==ACCESS. It is combinational from the strobes in IDLE and low in DONE.
- Slave strobes are registered: a request accepted at edge N is visible on the channel after edge N.
- Minimum access with a zero-wait slave:
  - request cycle (IDLE);
  - one ACCESS cycle;
  - DONE, with needWait_o low and rdata_o valid.
  - Result: three cycles, with data valid in the third.
- Each cycle of ch_needWait_i high extends ACCESS by one cycle.
- Unmapped access: IDLE then DONE, two cycles.
- Strobe changes by the CPU during ACCESS are ignored because the request is latched.

## Configuration
- Macro: EXT_MEM_ROUTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYC with the slave still waiting, the FSM aborts to DONE.
  - On abort: rdata_o = all ones for reads, err_o = 1, strobes drop.
- Undefined: no counter; ACCESS waits indefinitely; err_o reports unmapped accesses only.

## Structure
- Package ext_mem_router_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - function ch_decode(addr, sel_w) returning the channel index;
  - constant RDATA_TIMEOUT = '1.
- One sub-module, ext_mem_router_wdt (timeout counter with clear/enable/expired), instantiated only under the macro.

## Test plan
- Read ch0 at 0x000010 with zero wait and ch_rdata_i[ch0]=0xBEEF -> ch_re_o=0001 for 1 cycle, ch_addr_o=0x000010, needWait_o low in cycle 3, rdata_o=0xBEEF, err_o=0.
- Write 0x1234 to 0x600004 (ch3) with ch_needWait_i[3] high for 4 cycles -> ch_we_o=1000 for 5 cycles, ch_wdata_o=0x1234, needWait_o high 6 cycles.
- Read 0xE00000 (sel=7, NUM_CH=4) -> no channel strobe, rdata_o=0, err_o=1, needWait_o high 1 cycle.
- With the macro and TIMEOUT_CYC=8, read ch1 with ch_needWait_i[1] stuck high -> abort after 8 ACCESS cycles, rdata_o=0xFFFF, err_o=1. Without the macro, needWait_o is still high after 100 cycles.
- Assert rst during an ACCESS on ch2 -> ch_re_o=0 immediately, state IDLE. A new read of ch0 after release completes normally with err_o=0.
- Assert re_i and we_i together at 0x200000 -> write to ch1 only (ch_we_o=0010, ch_re_o=0000).
